ins_fetch: RTL and testbench
============================

# ins_fetch

Instruction fetch stage of the 8051 core, directly upstream of the instruction decoder. Owns the 16-bit program counter, reads opcode bytes and on-demand operand bytes from program ROM over a ready/strobe handshake, and holds the current opcode stable for the decoder until the controller requests the next fetch. It serves the controller's "fetch next instruction" path and its "read operand from ROM" path.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- TIMEOUT, 8, max cycles to wait for `rom_ready` before aborting a read (range 1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  pulse: fetch opcode at `pc`.
- arg_req  in  1  pulse: fetch next operand byte at `pc`.
- jump_en  in  1  pulse: load `pc` from `jump_addr`.
- jump_addr  in  16  branch target.
- rom_rd  out  1  ROM read strobe, one cycle per read.
- rom_addr  out  16  ROM address, valid while `rom_rd`=1.
- rom_data  in  8  ROM read data, valid when `rom_ready`=1.
- rom_ready  in  1  ROM data-valid strobe.
- instruction  out  8  current opcode, to decoder.
- ins_valid  out  1  `instruction` holds a fetched opcode.
- arg_data  out  8  last fetched operand byte.
- arg_valid  out  1  one-cycle pulse when `arg_data` updates.
- pc  out  16  address of the next byte to fetch.
- busy  out  1  read in progress.
- fetch_err  out  1  one-cycle pulse on ROM timeout.

## Operation
- States: IDLE, OP_REQ, OP_WAIT, VALID, ARG_REQ, ARG_WAIT.
- IDLE: `ins_valid`=0. `jump_en` -> `pc`<=`jump_addr`, stay. Else `fetch_req` -> OP_REQ.
- VALID: `ins_valid`=1, `instruction` held. `jump_en` -> `pc`<=`jump_addr`, stay VALID. Else `fetch_req` -> OP_REQ. Else `arg_req` -> ARG_REQ.
- Priority in IDLE/VALID: `jump_en` > `fetch_req` > `arg_req`. Only the highest-priority request is acted on.
- Entering OP_REQ clears `ins_valid`.
- OP_REQ / ARG_REQ: `rom_rd`=1 and `rom_addr`=`pc` for exactly one cycle, then go to OP_WAIT / ARG_WAIT. The wait counter is cleared.
- OP_WAIT: on `rom_ready`, `instruction`<=`rom_data`, `pc`<=`pc`+1, go to VALID.
- ARG_WAIT: on `rom_ready`, `arg_data`<=`rom_data`, `pc`<=`pc`+1, pulse `arg_valid`, go to VALID.
- Timeout: in either WAIT state, if `rom_ready` is not seen within TIMEOUT consecutive wait cycles, pulse `fetch_err`, leave `pc` unchanged, and go to IDLE. `ins_valid`=0 and `instruction`/`arg_data` keep their old values.
- `busy`=1 in OP_REQ, OP_WAIT, ARG_REQ and ARG_WAIT. While busy, `fetch_req`, `arg_req` and `jump_en` are ignored (not queued).
- `rom_ready` outside a WAIT state is ignored.
- `pc` arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000.
- `arg_req` in IDLE is ignored, since there is no current instruction.

## Timing
- Reset values:
  - state IDLE
  - `pc`=PC_RESET
  - `instruction`=8'h00, `arg_data`=8'h00
  - `ins_valid`=0, `arg_valid`=0, `rom_rd`=0, `busy`=0, `fetch_err`=0
  - `rom_addr`=PC_RESET
- Reset has priority over everything. Reset during a wait discards the pending read, and a later `rom_ready` is ignored.
- Request sampled at edge N -> `rom_rd`=1 during cycle N+1.
- `rom_ready` is sampled from cycle N+2 onward. With ready at cycle M, at edge M+1 `ins_valid`=1 (or `arg_valid`=1), `pc` is incremented and `busy`=0.
- Minimum fetch latency: request to `ins_valid` = 3 cycles.
- `rom_ready` in the same cycle as `rom_rd` is not sampled.
- `arg_valid` and `fetch_err` each last exactly one cycle.
- A back-to-back `fetch_req` is accepted in the first VALID cycle.
- The jump load takes effect at the next edge. A `fetch_req` in the following cycle uses the new `pc`.
- Timeout: with no ready, `fetch_err` rises TIMEOUT+2 cycles after the request.

## Test plan
- Reset, then `fetch_req` with ROM returning 8'hF9 one cycle after `rom_rd`: `rom_addr`=16'h0000, `instruction`=8'hF9, `ins_valid`=1 three cycles after the request, `pc`=16'h0001.
- In VALID, `arg_req` twice with ROM bytes 8'h12, 8'h34: two `arg_valid` pulses carrying 8'h12 then 8'h34, `instruction` unchanged, `ins_valid` held at 1, `pc`=16'h0003.
- `jump_en` with `jump_addr`=16'hFFFF, then two fetches: `rom_addr` is 16'hFFFF then 16'h0000, and `pc` ends at 16'h0001.
- Same-cycle `jump_en`=1 and `fetch_req`=1 in VALID: only `pc` loads, with no `rom_rd`. A `fetch_req` pulse during OP_WAIT is ignored, giving exactly one `rom_rd`.
- ROM never ready, TIMEOUT=8: one `fetch_err` pulse 10 cycles after the request, then state IDLE, `ins_valid`=0, `pc` unchanged. A late `rom_ready` afterwards has no effect.
- `rst` asserted during OP_WAIT: next cycle all outputs are at reset values. `rom_ready` the cycle after reset does not set `ins_valid`.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the program counter and reads opcode/operand bytes from
// program ROM over a rd/ready handshake, holding the opcode stable for the decoder.
module ins_fetch #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        arg_req,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic        rom_rd,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ready,
    output logic [7:0]  instruction,
    output logic        ins_valid,
    output logic [7:0]  arg_data,
    output logic        arg_valid,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        StIdle,
        StOpReq,
        StOpWait,
        StValid,
        StArgReq,
        StArgWait
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            pc          <= PC_RESET;
            rom_addr    <= PC_RESET;
            rom_rd      <= 1'b0;
            instruction <= 8'h00;
            ins_valid   <= 1'b0;
            arg_data    <= 8'h00;
            arg_valid   <= 1'b0;
            busy        <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 8'h00;
        end else begin
            rom_rd    <= 1'b0;
            arg_valid <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                StIdle, StValid: begin
                    // Only the highest-priority request is acted on; arg_req needs an opcode.
                    if (jump_en) begin
                        pc <= jump_addr;
                    end else if (fetch_req) begin
                        state     <= StOpReq;
                        rom_rd    <= 1'b1;
                        rom_addr  <= pc;
                        busy      <= 1'b1;
                        ins_valid <= 1'b0;
                    end else if (arg_req && state == StValid) begin
                        state    <= StArgReq;
                        rom_rd   <= 1'b1;
                        rom_addr <= pc;
                        busy     <= 1'b1;
                    end
                end
                StOpReq: begin
                    state    <= StOpWait;
                    wait_cnt <= 8'h00;
                end
                StArgReq: begin
                    state    <= StArgWait;
                    wait_cnt <= 8'h00;
                end
                StOpWait, StArgWait: begin
                    if (rom_ready) begin
                        if (state == StOpWait) begin
                            instruction <= rom_data;
                        end else begin
                            arg_data  <= rom_data;
                            arg_valid <= 1'b1;
                        end
                        pc        <= pc + 16'h0001;
                        ins_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StValid;
                    end else if (wait_cnt == TimeoutLast) begin
                        // Abort: pc stays on the byte that failed so it can be retried.
                        fetch_err <= 1'b1;
                        ins_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: fetch, operands, jump wrap, priority, timeout and reset abort.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        arg_req = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ready = 1'b0;
    logic [7:0]  instruction;
    logic        ins_valid;
    logic [7:0]  arg_data;
    logic        arg_valid;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_err;

    int n_cmp = 0;
    int n_fail = 0;
    int rd_cnt = 0;

    ins_fetch #(.PC_RESET(16'h0000), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .arg_req(arg_req), .jump_en(jump_en),
        .jump_addr(jump_addr), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_ready(rom_ready), .instruction(instruction), .ins_valid(ins_valid),
        .arg_data(arg_data), .arg_valid(arg_valid), .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rd_cnt = rd_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_cmp++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); end
        n_cmp++; if ({instruction, arg_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h %h want 00 00", instruction, arg_data); end
        n_cmp++; if ({ins_valid, arg_valid, rom_rd, busy, fetch_err} !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {ins_valid, arg_valid, rom_rd, busy, fetch_err}); end
    endtask

    task automatic test_fetch();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_cmp++; if ({rom_rd, busy} !== 2'b11) begin n_fail++; $display("FAIL fetch_rd: got rd=%b busy=%b want 1 1", rom_rd, busy); end
        n_cmp++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL fetch_addr: got %h want 0000", rom_addr); end
        tick();
        rom_ready = 1'b1;
        rom_data = 8'hF9;
        n_cmp++; if ({rom_rd, ins_valid} !== 2'b00) begin n_fail++; $display("FAIL fetch_wait: got rd=%b valid=%b want 0 0", rom_rd, ins_valid); end
        tick();
        rom_ready = 1'b0;
        n_cmp++; if ({ins_valid, instruction} !== {1'b1, 8'hF9}) begin n_fail++; $display("FAIL fetch_ins: got v=%b %h want 1 f9", ins_valid, instruction); end
        n_cmp++; if ({pc, busy} !== {16'h0001, 1'b0}) begin n_fail++; $display("FAIL fetch_pc: got %h busy=%b want 0001 0", pc, busy); end
    endtask

    task automatic test_args();
        logic [7:0] bytes [2];
        bytes[0] = 8'h12;
        bytes[1] = 8'h34;
        for (int i = 0; i < 2; i++) begin
            arg_req = 1'b1;
            tick();
            arg_req = 1'b0;
            n_cmp++; if ({rom_rd, rom_addr} !== {1'b1, 16'(i + 1)}) begin n_fail++; $display("FAIL arg_rd%0d: got rd=%b %h want 1 %h", i, rom_rd, rom_addr, 16'(i + 1)); end
            tick();
            rom_ready = 1'b1;
            rom_data = bytes[i];
            tick();
            rom_ready = 1'b0;
            n_cmp++; if ({arg_valid, arg_data} !== {1'b1, bytes[i]}) begin n_fail++; $display("FAIL arg_data%0d: got v=%b %h want 1 %h", i, arg_valid, arg_data, bytes[i]); end
            n_cmp++; if ({ins_valid, instruction} !== {1'b1, 8'hF9}) begin n_fail++; $display("FAIL arg_ins%0d: got v=%b %h want 1 f9", i, ins_valid, instruction); end
            tick();
            n_cmp++; if (arg_valid !== 1'b0) begin n_fail++; $display("FAIL arg_pulse%0d: got %b want 0", i, arg_valid); end
        end
        n_cmp++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL arg_pc: got %h want 0003", pc); end
    endtask

    // Second fetch is issued in the first VALID cycle of the first (back-to-back).
    task automatic test_jump_wrap();
        logic [15:0] addrs [2];
        addrs[0] = 16'hFFFF;
        addrs[1] = 16'h0000;
        jump_en = 1'b1;
        jump_addr = 16'hFFFF;
        tick();
        jump_en = 1'b0;
        n_cmp++; if ({pc, rom_rd, ins_valid} !== {16'hFFFF, 1'b0, 1'b1}) begin n_fail++; $display("FAIL jump_load: got %h rd=%b v=%b want ffff 0 1", pc, rom_rd, ins_valid); end
        for (int i = 0; i < 2; i++) begin
            fetch_req = 1'b1;
            tick();
            fetch_req = 1'b0;
            n_cmp++; if ({rom_rd, rom_addr} !== {1'b1, addrs[i]}) begin n_fail++; $display("FAIL jump_fetch%0d: got rd=%b %h want 1 %h", i, rom_rd, rom_addr, addrs[i]); end
            tick();
            rom_ready = 1'b1;
            rom_data = 8'h40 + 8'(i);
            tick();
            rom_ready = 1'b0;
            n_cmp++; if ({ins_valid, instruction} !== {1'b1, 8'h40 + 8'(i)}) begin n_fail++; $display("FAIL jump_ins%0d: got v=%b %h want 1 %h", i, ins_valid, instruction, 8'h40 + 8'(i)); end
        end
        n_cmp++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL jump_wrap_pc: got %h want 0001", pc); end
    endtask

    task automatic test_priority();
        rd_cnt = 0;
        jump_en = 1'b1;
        fetch_req = 1'b1;
        jump_addr = 16'h0100;
        tick();
        jump_en = 1'b0;
        fetch_req = 1'b0;
        n_cmp++; if ({pc, rom_rd, busy} !== {16'h0100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL prio_jump: got %h rd=%b busy=%b want 0100 0 0", pc, rom_rd, busy); end
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_cmp++; if (rom_addr !== 16'h0100) begin n_fail++; $display("FAIL prio_addr: got %h want 0100", rom_addr); end
        tick();
        fetch_req = 1'b1;
        jump_en = 1'b1;
        jump_addr = 16'h2222;
        tick();
        fetch_req = 1'b0;
        jump_en = 1'b0;
        rom_ready = 1'b1;
        rom_data = 8'hA5;
        tick();
        rom_ready = 1'b0;
        n_cmp++; if ({ins_valid, instruction, pc} !== {1'b1, 8'hA5, 16'h0101}) begin n_fail++; $display("FAIL prio_ins: got v=%b %h %h want 1 a5 0101", ins_valid, instruction, pc); end
        tick();
        tick();
        n_cmp++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL prio_rd_count: got %0d want 1", rd_cnt); end
    endtask

    task automatic test_timeout();
        int k;
        int early;
        early = 0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        k = 1;
        while (fetch_err !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        n_cmp++; if (k !== 10) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want 10", k); end
        n_cmp++; if ({ins_valid, busy, pc, instruction} !== {1'b0, 1'b0, 16'h0101, 8'hA5}) begin n_fail++; $display("FAIL timeout_state: got v=%b busy=%b %h %h want 0 0 0101 a5", ins_valid, busy, pc, instruction); end
        tick();
        n_cmp++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", fetch_err); end
        rom_ready = 1'b1;
        rom_data = 8'h77;
        arg_req = 1'b1;
        tick();
        rom_ready = 1'b0;
        arg_req = 1'b0;
        n_cmp++; if ({ins_valid, rom_rd, busy, instruction, pc} !== {3'b000, 8'hA5, 16'h0101}) begin n_fail++; $display("FAIL timeout_late: got v=%b rd=%b busy=%b %h %h want 000 a5 0101", ins_valid, rom_rd, busy, instruction, pc); end
    endtask

    task automatic test_reset_wait();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({pc, rom_addr, instruction, arg_data} !== 48'h0) begin n_fail++; $display("FAIL rstwait_data: got %h %h %h %h want all 0", pc, rom_addr, instruction, arg_data); end
        n_cmp++; if ({ins_valid, arg_valid, rom_rd, busy, fetch_err} !== 5'b00000) begin n_fail++; $display("FAIL rstwait_flags: got %b want 00000", {ins_valid, arg_valid, rom_rd, busy, fetch_err}); end
        rom_ready = 1'b1;
        rom_data = 8'h55;
        tick();
        rom_ready = 1'b0;
        n_cmp++; if ({ins_valid, instruction, pc} !== {1'b0, 8'h00, 16'h0000}) begin n_fail++; $display("FAIL rstwait_late: got v=%b %h %h want 0 00 0000", ins_valid, instruction, pc); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_args();
        test_jump_wrap();
        test_priority();
        test_timeout();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
